// File: rtl/i2c_mst_ctrl_byte.sv
// I2C master byte controller: sequences START/WRITE/READ/ACK/STOP commands
// for a bit-level controller from host request bits.
module i2c_mst_ctrl_byte (
  input  logic       clk,
  input  logic       rstn,
  input  logic       ena,
  input  logic       start,
  input  logic       stop,
  input  logic       read,
  input  logic       write,
  input  logic       ack_in,
  input  logic [7:0] din,
  output logic       cmd_ack,
  output logic       ack_out,
  output logic [7:0] dout,
  output logic       i2c_al,
  output logic [3:0] core_cmd,
  output logic       core_txd,
  input  logic       core_ack,
  input  logic       core_rxd,
  input  logic       core_al
);
  localparam logic [3:0] CMD_NOP   = 4'b0000;
  localparam logic [3:0] CMD_START = 4'b0001;
  localparam logic [3:0] CMD_STOP  = 4'b0010;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_READ  = 4'b1000;

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_WRITE, ST_READ, ST_ACK, ST_STOP} state_t;

  state_t     state_q, state_d;
  logic [7:0] sr_q, sr_d, dout_q, dout_d;
  logic [2:0] cnt_q, cnt_d;
  logic [3:0] cmd_q, cmd_d;
  logic       txd_q, txd_d, cmd_ack_q, cmd_ack_d, ack_out_q, ack_out_d;
  logic       al_q, al_d, core_al_q, rd_q, rd_d;
  logic       go;

  // cmd_ack_q blocks a restart while the host is still dropping its requests
  assign go = (start | stop | read | write) & ~cmd_ack_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      sr_q      <= 8'h00;
      dout_q    <= 8'h00;
      cnt_q     <= 3'd0;
      cmd_q     <= CMD_NOP;
      txd_q     <= 1'b0;
      cmd_ack_q <= 1'b0;
      ack_out_q <= 1'b0;
      al_q      <= 1'b0;
      core_al_q <= 1'b0;
      rd_q      <= 1'b0;
    end else if (ena) begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      dout_q    <= dout_d;
      cnt_q     <= cnt_d;
      cmd_q     <= cmd_d;
      txd_q     <= txd_d;
      cmd_ack_q <= cmd_ack_d;
      ack_out_q <= ack_out_d;
      al_q      <= al_d;
      core_al_q <= core_al;
      rd_q      <= rd_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    dout_d    = dout_q;
    cnt_d     = cnt_q;
    cmd_d     = cmd_q;
    txd_d     = txd_q;
    ack_out_d = ack_out_q;
    rd_d      = rd_q;
    cmd_ack_d = 1'b0;
    al_d      = core_al & ~core_al_q;
    if (core_al) begin
      state_d = ST_IDLE;
      cmd_d   = CMD_NOP;
      cnt_d   = 3'd0;
      txd_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (go) begin
          sr_d  = din;
          cnt_d = 3'd7;
          if (start) begin
            state_d = ST_START; cmd_d = CMD_START;
          end else if (write) begin
            state_d = ST_WRITE; cmd_d = CMD_WRITE; txd_d = din[7]; rd_d = 1'b0;
          end else if (read) begin
            state_d = ST_READ; cmd_d = CMD_READ; rd_d = 1'b1;
          end else begin
            state_d = ST_STOP; cmd_d = CMD_STOP;
          end
        end
        ST_START: if (core_ack) begin
          if (write) begin
            state_d = ST_WRITE; cmd_d = CMD_WRITE; txd_d = sr_q[7]; rd_d = 1'b0;
          end else if (read) begin
            state_d = ST_READ; cmd_d = CMD_READ; rd_d = 1'b1;
          end else if (stop) begin
            state_d = ST_STOP; cmd_d = CMD_STOP;
          end else begin
            state_d = ST_IDLE; cmd_d = CMD_NOP; cmd_ack_d = 1'b1;
          end
        end
        ST_WRITE: if (core_ack) begin
          sr_d = {sr_q[6:0], 1'b0};
          if (cnt_q == 3'd0) begin
            state_d = ST_ACK; cmd_d = CMD_READ;
          end else begin
            cnt_d = cnt_q - 3'd1;
            txd_d = sr_q[6];
          end
        end
        ST_READ: if (core_ack) begin
          sr_d = {sr_q[6:0], core_rxd};
          if (cnt_q == 3'd0) begin
            state_d = ST_ACK; cmd_d = CMD_WRITE; txd_d = ack_in;
            dout_d  = {sr_q[6:0], core_rxd};
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        ST_ACK: if (core_ack) begin
          if (!rd_q) ack_out_d = core_rxd;
          if (stop) begin
            state_d = ST_STOP; cmd_d = CMD_STOP;
          end else begin
            state_d = ST_IDLE; cmd_d = CMD_NOP; cmd_ack_d = 1'b1;
          end
        end
        ST_STOP: if (core_ack) begin
          state_d = ST_IDLE; cmd_d = CMD_NOP; cmd_ack_d = 1'b1;
        end
        default: begin
          state_d = ST_IDLE; cmd_d = CMD_NOP;
        end
      endcase
    end
  end

  assign cmd_ack  = cmd_ack_q;
  assign ack_out  = ack_out_q;
  assign dout     = dout_q;
  assign i2c_al   = al_q;
  assign core_cmd = cmd_q;
  assign core_txd = txd_q;
endmodule

// File: tb/tb_i2c_mst_ctrl_byte.sv
// Bench for i2c_mst_ctrl_byte: a behavioural bit controller acks commands
// after random delays; expected command sequences are built from the byte rules.
module tb_i2c_mst_ctrl_byte;
  localparam logic [3:0] C_NOP = 4'd0, C_START = 4'd1, C_STOP = 4'd2, C_WRITE = 4'd4, C_READ = 4'd8;

  logic clk = 0, rstn = 0, ena = 1;
  logic start = 0, stop = 0, read = 0, write = 0, ack_in = 0;
  logic [7:0] din = 0;
  logic cmd_ack, ack_out, i2c_al, core_txd;
  logic [7:0] dout;
  logic [3:0] core_cmd;
  logic core_ack = 0, core_rxd = 0, core_al = 0;

  int checks = 0, errors = 0;
  int ack_cnt = 0, ack_base = 0;
  int al_at = -1;

  typedef struct packed {logic [3:0] cmd; logic txd;} ev_t;
  ev_t  log_q[$], exp_q[$];
  logic rx_q[$];

  i2c_mst_ctrl_byte dut (
    .clk(clk), .rstn(rstn), .ena(ena), .start(start), .stop(stop), .read(read),
    .write(write), .ack_in(ack_in), .din(din), .cmd_ack(cmd_ack), .ack_out(ack_out),
    .dout(dout), .i2c_al(i2c_al), .core_cmd(core_cmd), .core_txd(core_txd),
    .core_ack(core_ack), .core_rxd(core_rxd), .core_al(core_al)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (cmd_ack) ack_cnt++;

  // Bit-controller model: logs each command it completes, supplies read bits
  initial begin : bitctl
    ev_t e;
    int  d;
    forever begin
      @(negedge clk);
      if (rstn && core_cmd != C_NOP) begin
        d = $urandom_range(0, 3);
        repeat (d) @(negedge clk);
        while (!ena) @(negedge clk);
        if (rstn && core_cmd != C_NOP) begin
          if (al_at >= 0 && log_q.size() == al_at) begin
            al_at = -1;
            core_al = 1; @(negedge clk); core_al = 0;
          end else begin
            e.cmd = core_cmd; e.txd = core_txd;
            log_q.push_back(e);
            core_rxd = 1'b1;
            if (core_cmd == C_READ && rx_q.size() > 0) core_rxd = rx_q.pop_front();
            core_ack = 1; @(negedge clk); core_ack = 0;
          end
        end
      end
    end
  end

  task automatic drive(input logic s, input logic w, input logic r, input logic p,
                       input logic [7:0] d, input logic ai, input logic [7:0] rb, input logic sa);
    ev_t e;
    exp_q.delete(); rx_q.delete(); log_q.delete();
    if (s) begin e.cmd = C_START; e.txd = 0; exp_q.push_back(e); end
    if (w) begin
      for (int i = 7; i >= 0; i--) begin e.cmd = C_WRITE; e.txd = d[i]; exp_q.push_back(e); end
      e.cmd = C_READ; e.txd = 0; exp_q.push_back(e);
      rx_q.push_back(sa);
    end else if (r) begin
      for (int i = 7; i >= 0; i--) begin e.cmd = C_READ; e.txd = 0; exp_q.push_back(e); rx_q.push_back(rb[i]); end
      e.cmd = C_WRITE; e.txd = ai; exp_q.push_back(e);
    end
    if (p) begin e.cmd = C_STOP; e.txd = 0; exp_q.push_back(e); end
    ack_base = ack_cnt;
    din = d; ack_in = ai;
    start = s; write = w; read = r; stop = p;
  endtask

  task automatic finish_txn(input string name, input logic w, input logic r, input logic sa, input logic [7:0] rb);
    int n = 0;
    int bad = -1;
    while (!cmd_ack && n < 3000) begin @(negedge clk); n++; end
    checks++;
    if (cmd_ack !== 1'b1) begin errors++; $display("FAIL %s cmd_ack timeout", name); end
    start = 0; write = 0; read = 0; stop = 0;
    repeat (4) @(negedge clk);
    checks++;
    if (ack_cnt - ack_base != 1) begin errors++; $display("FAIL %s cmd_ack count got %0d want 1", name, ack_cnt - ack_base); end
    checks++;
    if (log_q.size() != exp_q.size()) begin
      errors++; $display("FAIL %s seq length got %0d want %0d", name, log_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++)
        if (bad < 0 && (log_q[i].cmd !== exp_q[i].cmd ||
            (exp_q[i].cmd == C_WRITE && log_q[i].txd !== exp_q[i].txd))) bad = i;
      if (bad >= 0) begin
        errors++;
        $display("FAIL %s seq[%0d] got cmd=%h txd=%b want cmd=%h txd=%b", name, bad,
                 log_q[bad].cmd, log_q[bad].txd, exp_q[bad].cmd, exp_q[bad].txd);
      end
    end
    if (w) begin
      checks++;
      if (ack_out !== sa) begin errors++; $display("FAIL %s ack_out got %b want %b", name, ack_out, sa); end
    end else if (r) begin
      checks++;
      if (dout !== rb) begin errors++; $display("FAIL %s dout got %h want %h", name, dout, rb); end
    end
    checks++;
    if (core_cmd !== C_NOP) begin errors++; $display("FAIL %s idle core_cmd got %h want 0", name, core_cmd); end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({core_cmd, core_txd, ack_out, cmd_ack, i2c_al, dout} !== 16'h0) begin
      errors++; $display("FAIL reset outputs got %h want 0", {core_cmd, core_txd, ack_out, cmd_ack, i2c_al, dout});
    end
    @(posedge clk); #3 rstn = 1;
    repeat (3) @(negedge clk);
    checks++;
    if (core_cmd !== C_NOP) begin errors++; $display("FAIL reset idle core_cmd got %h want 0", core_cmd); end
  endtask

  task automatic test_write_ack();
    drive(1, 1, 0, 1, 8'hA5, 0, 8'h00, 0);
    finish_txn("write_a5", 1, 0, 0, 8'h00);
  endtask

  task automatic test_read_nack();
    drive(0, 0, 1, 0, 8'h00, 1, 8'h3C, 0);
    finish_txn("read_3c", 0, 1, 0, 8'h3C);
  endtask

  task automatic test_stop_only();
    drive(0, 0, 0, 1, 8'h00, 0, 8'h00, 0);
    finish_txn("stop_only", 0, 0, 0, 8'h00);
  endtask

  task automatic test_arb_lost();
    int n = 0;
    al_at = 3;
    drive(0, 1, 0, 0, 8'hFF, 0, 8'h00, 0);
    while (!i2c_al && n < 3000) begin @(negedge clk); n++; end
    write = 0;
    checks++;
    if (i2c_al !== 1'b1) begin errors++; $display("FAIL al pulse missing got %b want 1", i2c_al); end
    checks++;
    if (core_cmd !== C_NOP) begin errors++; $display("FAIL al core_cmd got %h want 0", core_cmd); end
    @(negedge clk);
    checks++;
    if (i2c_al !== 1'b0) begin errors++; $display("FAIL al pulse width got %b want 0", i2c_al); end
    repeat (5) @(negedge clk);
    checks++;
    if (ack_cnt != ack_base) begin errors++; $display("FAIL al cmd_ack count got %0d want 0", ack_cnt - ack_base); end
    checks++;
    if (log_q.size() != 3 || core_cmd !== C_NOP) begin
      errors++; $display("FAIL al after bits got %0d cmd=%h want 3 cmd=0", log_q.size(), core_cmd);
    end
    al_at = -1;
  endtask

  task automatic test_ena_freeze();
    int n = 0;
    logic [7:0] d;
    logic sa;
    logic [15:0] snap;
    d = 8'($urandom); sa = 1'($urandom_range(0, 1));
    drive(0, 1, 0, 1, d, 0, 8'h00, sa);
    while (log_q.size() < 3 && n < 3000) begin @(negedge clk); n++; end
    checks++;
    if (log_q.size() < 3) begin errors++; $display("FAIL ena wait got %0d bits want 3", log_q.size()); end
    @(posedge clk); #2 ena = 0;
    snap = {core_cmd, core_txd, cmd_ack, ack_out, i2c_al, dout};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({core_cmd, core_txd, cmd_ack, ack_out, i2c_al, dout} !== snap) begin
        errors++; $display("FAIL ena freeze cyc %0d got %h want %h", i,
                           {core_cmd, core_txd, cmd_ack, ack_out, i2c_al, dout}, snap);
      end
    end
    @(posedge clk); #2 ena = 1;
    finish_txn("ena_resume", 1, 0, sa, 8'h00);
  endtask

  task automatic test_reset_mid_read();
    int n = 0;
    logic [7:0] rb;
    rb = 8'($urandom);
    drive(0, 0, 1, 0, 8'h00, 0, rb, 0);
    while (log_q.size() < 5 && n < 3000) begin @(negedge clk); n++; end
    #2 rstn = 0; read = 0;
    #1;
    checks++;
    if (core_cmd !== C_NOP) begin errors++; $display("FAIL rst core_cmd got %h want 0", core_cmd); end
    checks++;
    if (dout !== 8'h00) begin errors++; $display("FAIL rst dout got %h want 0", dout); end
    checks++;
    if ({core_txd, ack_out, cmd_ack, i2c_al} !== 4'b0) begin
      errors++; $display("FAIL rst flags got %b want 0000", {core_txd, ack_out, cmd_ack, i2c_al});
    end
    @(posedge clk); #3 rstn = 1;
    repeat (5) @(negedge clk);
    checks++;
    if (core_cmd !== C_NOP) begin errors++; $display("FAIL rst no restart core_cmd got %h want 0", core_cmd); end
    drive(0, 1, 0, 0, 8'h81, 0, 8'h00, 0);
    finish_txn("post_rst_81", 1, 0, 0, 8'h00);
  endtask

  task automatic test_random();
    logic s, w, r, p, ai, sa;
    logic [7:0] d, rb;
    for (int k = 0; k < 14; k++) begin
      do begin
        s = 1'($urandom_range(0, 1)); w = 1'($urandom_range(0, 1));
        r = 1'($urandom_range(0, 1)); p = 1'($urandom_range(0, 1));
      end while (!(s | w | r | p));
      d = 8'($urandom); rb = 8'($urandom);
      ai = 1'($urandom_range(0, 1)); sa = 1'($urandom_range(0, 1));
      drive(s, w, r, p, d, ai, rb, sa);
      finish_txn($sformatf("rand%0d", k), w, r, sa, rb);
    end
  endtask

  initial begin
    test_reset();
    test_write_ack();
    test_read_nack();
    test_stop_only();
    test_arb_lost();
    test_ena_freeze();
    test_random();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/i2c_mst_ctrl_byte.md
I2C_MST_CTRL_BYTE -- requirements
Module: i2c_mst_ctrl_byte

Interface
REQ-001 SHALL have port clk, input, 1 bit: system clock; all state updates on its rising edge.
REQ-002 SHALL have port rstn, input, 1 bit: asynchronous active-low reset.
REQ-003 SHALL have port ena, input, 1 bit: core enable; low freezes all registers.
REQ-004 SHALL have ports start, stop, read, write, input, 1 bit each: host command request bits; host holds them until cmd_ack.
REQ-005 SHALL have port ack_in, input, 1 bit: ACK value driven after a read byte (0 = ACK, 1 = NACK).
REQ-006 SHALL have port din, input, 8 bits: byte to transmit, MSB first.
REQ-007 SHALL have port cmd_ack, output, 1 bit: one-cycle pulse marking completion of the host command.
REQ-008 SHALL have port ack_out, output, 1 bit: ACK bit received after a write byte.
REQ-009 SHALL have port dout, output, 8 bits: last received byte.
REQ-010 SHALL have port i2c_al, output, 1 bit: registered one-cycle arbitration-lost pulse.
REQ-011 SHALL have port core_cmd, output, 4 bits: bit-controller command (I2C_CMD_NOP/START/STOP/WRITE/READ from i2c_master_defines.v).
REQ-012 SHALL have port core_txd, output, 1 bit: bit value sent to the bit controller.
REQ-013 SHALL have port core_ack, input, 1 bit: bit-controller command-complete pulse.
REQ-014 SHALL have port core_rxd, input, 1 bit: bit sampled by the bit controller.
REQ-015 SHALL have port core_al, input, 1 bit: bit-controller arbitration lost.

Function
REQ-016 FSM states SHALL be IDLE, START, WRITE, READ, ACK, STOP; core_cmd, core_txd, cmd_ack, ack_out, dout and i2c_al are registered.
REQ-017 IDLE: when cmd_ack is low and any request is high, the FSM SHALL leave IDLE on the next edge; priority start > write > read > stop; sr loaded with din, bit counter loaded with 7.
REQ-018 START SHALL issue core_cmd=START; on core_ack go to WRITE if write, else READ if read, else STOP if stop, else IDLE with cmd_ack.
REQ-019 WRITE SHALL issue core_cmd=WRITE with core_txd=sr[7]; on each core_ack shift sr left by one and decrement the counter; the core_ack at count 0 moves to ACK.
REQ-020 READ SHALL issue core_cmd=READ; on each core_ack shift core_rxd into sr[0]; the core_ack at count 0 moves to ACK and loads dout with the completed byte.
REQ-021 ACK after a write SHALL issue READ and latch ack_out=core_rxd on core_ack; ACK after a read SHALL issue WRITE with core_txd=ack_in.
REQ-022 On ACK completion the FSM SHALL go to STOP if stop is high, else to IDLE with cmd_ack.
REQ-023 A request with only stop high SHALL execute STOP alone.
REQ-024 STOP SHALL issue core_cmd=STOP; on core_ack go to IDLE with cmd_ack.
REQ-025 core_cmd SHALL change only in the cycle after a core_ack (or after leaving IDLE), and SHALL be NOP in IDLE, so the bit controller never re-executes a completed command.
REQ-026 core_al high SHALL force IDLE, core_cmd=NOP and counter=0; cmd_ack stays low; i2c_al pulses for one cycle. This takes priority over core_ack in the same cycle.
REQ-027 Requests that change while busy SHALL be ignored except stop, which is sampled at ACK completion.

Reset
REQ-028 When rstn is low, the block SHALL be in IDLE with sr, dout and counter at 0 and core_cmd=NOP, and outputs core_txd, ack_out, cmd_ack and i2c_al at 0, regardless of clk.
REQ-029 Reset asserted mid-byte SHALL abort immediately; after release, no command is issued until a new request.

Verification
REQ-030 start=write=stop=1, din=0xA5, slave ACKs -> core_cmd START, 8xWRITE with core_txd 1,0,1,0,0,1,0,1, READ, STOP; ack_out=0; exactly one cmd_ack.
REQ-031 read=1, ack_in=1, model bits 0x3C -> 8xREAD, then WRITE with core_txd=1; dout=0x3C; cmd_ack once; no STOP.
REQ-032 write=1, din=0xFF, core_al asserted on bit 3 -> IDLE next cycle, core_cmd=NOP, i2c_al single pulse, no cmd_ack.
REQ-033 ena=0 held 10 cycles mid-write -> all outputs and sr unchanged; resumes correctly afterwards.
REQ-034 rstn pulsed low during READ bit 5 -> outputs at reset values asynchronously; a new write of 0x81 afterwards completes correctly.
REQ-035 stop=1 only -> single STOP command, then cmd_ack.
